// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter: request payload and grant source.
package wb_pkg;

   localparam int unsigned DataWidth    = 32;
   localparam int unsigned RegAddrWidth = 5;

   typedef struct packed {
      logic [RegAddrWidth-1:0] rd;
      logic [DataWidth-1:0]    data;
   } wb_req_t;

   typedef enum logic [1:0] {
      WB_NONE   = 2'd0,
      WB_LOAD   = 2'd1,
      WB_BUF    = 2'd2,
      WB_BYPASS = 2'd3
   } wb_src_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Pipeline/load request inputs and register-file write outputs of the write-port arbiter.
interface wb_port_arbiter_if
   import wb_pkg::*;
#(
   parameter int unsigned Depth = 2
) ();

   localparam int unsigned CntWidth = $clog2(Depth) + 1;

   logic                    ex_valid;
   logic                    ex_ready;
   logic [RegAddrWidth-1:0] ex_rd;
   logic [DataWidth-1:0]    ex_data;
   logic                    ld_valid;
   logic [RegAddrWidth-1:0] ld_rd;
   logic [DataWidth-1:0]    ld_data;
   logic                    rf_we;
   logic [RegAddrWidth-1:0] rf_waddr;
   logic [DataWidth-1:0]    rf_wdata;
   logic [CntWidth-1:0]     ex_pending;

   modport master (
      output ex_valid, ex_rd, ex_data, ld_valid, ld_rd, ld_data,
      input  ex_ready, rf_we, rf_waddr, rf_wdata, ex_pending
   );

   modport slave (
      input  ex_valid, ex_rd, ex_data, ld_valid, ld_rd, ld_data,
      output ex_ready, rf_we, rf_waddr, rf_wdata, ex_pending
   );

endinterface

// File: rtl/wb_fifo.sv
// In-order buffer of pending pipeline results; pointers carry one wrap bit so
// occupancy is a plain modulo-2*Depth subtraction.
module wb_fifo
   import wb_pkg::*;
#(
   parameter  int unsigned Depth     = 2,
   localparam int unsigned AddrWidth = $clog2(Depth),
   localparam int unsigned CntWidth  = AddrWidth + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_push,
   input  wb_req_t             i_push_data,
   input  logic                i_pop,
   output wb_req_t             o_head_c,
   output logic                o_full_c,
   output logic                o_empty_c,
   output logic [CntWidth-1:0] o_count_c
);

   logic [CntWidth-1:0] r_wr_ptr;
   logic [CntWidth-1:0] r_rd_ptr;
   wb_req_t             r_mem [Depth];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + CntWidth'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + CntWidth'(1);
      end
   end

   // Payload storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr[AddrWidth-1:0]] <= i_push_data;
   end

   assign o_head_c  = r_mem[r_rd_ptr[AddrWidth-1:0]];
   assign o_count_c = r_wr_ptr - r_rd_ptr;
   assign o_empty_c = (r_wr_ptr == r_rd_ptr);
   assign o_full_c  = (r_wr_ptr[AddrWidth] != r_rd_ptr[AddrWidth]) &&
                      (r_wr_ptr[AddrWidth-1:0] == r_rd_ptr[AddrWidth-1:0]);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port: loads always win, pipeline results are
// buffered in order (or bypassed when idle) and written one cycle after grant.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input logic              clk,
   input logic              rst_n,
   wb_port_arbiter_if.slave bus
);

   localparam int unsigned CntWidth = $clog2(Depth) + 1;

   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_fifo_push;
   logic                    w_pop;
   logic [CntWidth-1:0]     w_count;
   wb_req_t                 w_ex_req;
   wb_req_t                 w_ld_req;
   wb_req_t                 w_head;
   wb_req_t                 w_sel;
   wb_src_e                 w_src;

   logic                    r_we;
   logic [RegAddrWidth-1:0] r_waddr;
   logic [DataWidth-1:0]    r_wdata;

   assign w_ex_req = '{rd: bus.ex_rd, data: bus.ex_data};
   assign w_ld_req = '{rd: bus.ld_rd, data: bus.ld_data};
   assign w_push   = bus.ex_valid && !w_full;

   // Fixed-priority grant: load, then buffer head, then bypass of a fresh push.
   always_comb begin
      w_src = WB_NONE;
      w_sel = '0;
      if (bus.ld_valid) begin
         w_src = WB_LOAD;
         w_sel = w_ld_req;
      end else if (!w_empty) begin
         w_src = WB_BUF;
         w_sel = w_head;
      end else if (w_push) begin
         w_src = WB_BYPASS;
         w_sel = w_ex_req;
      end
   end

   assign w_fifo_push = w_push && (w_src != WB_BYPASS);
   assign w_pop       = (w_src == WB_BUF);

   wb_fifo #(
      .Depth (Depth)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_fifo_push),
      .i_push_data (w_ex_req),
      .i_pop       (w_pop),
      .o_head_c    (w_head),
      .o_full_c    (w_full),
      .o_empty_c   (w_empty),
      .o_count_c   (w_count)
   );

   // Registered write; x0 requests are consumed but never enable the write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we    <= (w_src != WB_NONE) && (w_sel.rd != '0);
         r_waddr <= w_sel.rd;
         r_wdata <= w_sel.data;
      end
   end

   assign bus.rf_we      = r_we;
   assign bus.rf_waddr   = r_waddr;
   assign bus.rf_wdata   = r_wdata;
   assign bus.ex_ready   = !w_full;
   assign bus.ex_pending = w_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// every register-file write and the cycle it must appear in.
module tb_wb_port_arbiter;
   import wb_pkg::*;

   localparam int unsigned Depth = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   wb_port_arbiter_if #(.Depth(Depth)) bus ();

   wb_port_arbiter #(.Depth(Depth)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t    exp_q[$];
   wb_req_t model_buf[$];
   int      cyc   = 0;
   int      n_vec = 0;
   int      n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every write must match the oldest expectation, in its exact cycle.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (bus.rf_we) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: cycle %0d got rd=%0d data=%h, expected no write",
                     cyc, bus.rf_waddr, bus.rf_wdata);
         end else begin
            e = exp_q.pop_front();
            if (bus.rf_waddr !== e.rd || bus.rf_wdata !== e.data || cyc != e.due) begin
               n_err++;
               $display("FAIL write: cycle %0d got rd=%0d data=%h, expected rd=%0d data=%h at cycle %0d",
                        cyc, bus.rf_waddr, bus.rf_wdata, e.rd, e.data, e.due);
            end
         end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         n_vec++;
         n_err++;
         e = exp_q.pop_front();
         $display("FAIL missing_write: cycle %0d got no write, expected rd=%0d data=%h",
                  cyc, e.rd, e.data);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
      if (rd != 5'd0) exp_q.push_back('{rd: rd, data: data, due: cyc + 1});
   endtask

   // One cycle of stimulus: check visible state, drive inputs, advance the model.
   task automatic step(input bit ldv, input logic [4:0] ldrd, input logic [31:0] ldd,
                       input bit exv, input logic [4:0] exrd, input logic [31:0] exd);
      bit      acc;
      wb_req_t h;
      @(negedge clk);
      chk("ex_pending", 32'(bus.ex_pending), 32'(model_buf.size()));
      chk("ex_ready", 32'(bus.ex_ready), 32'(model_buf.size() < Depth));
      bus.ld_valid = ldv;
      bus.ld_rd    = ldrd;
      bus.ld_data  = ldd;
      bus.ex_valid = exv;
      bus.ex_rd    = exrd;
      bus.ex_data  = exd;
      acc = exv && (model_buf.size() < Depth);
      if (ldv) begin
         expect_write(ldrd, ldd);
         if (acc) model_buf.push_back('{rd: exrd, data: exd});
      end else if (model_buf.size() > 0) begin
         h = model_buf.pop_front();
         expect_write(h.rd, h.data);
         if (acc) model_buf.push_back('{rd: exrd, data: exd});
      end else if (acc) begin
         expect_write(exrd, exd);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
      chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
      chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
      chk("rst_ex_pending", 32'(bus.ex_pending), 32'd0);
      chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_rd    = '0;
      bus.ld_data  = '0;
      bus.ex_valid = 1'b0;
      bus.ex_rd    = '0;
      bus.ex_data  = '0;
      #1;
      chk_reset_outputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Bypass when idle.
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11);
      idle(2);

      // Load and pipeline result in the same cycle.
      step(1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB);
      idle(3);

      // Sustained loads fill the buffer; stalled results are re-presented afterwards.
      for (int i = 0; i < 4; i++)
         step(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b1, 5'(20 + i), 32'h200 + 32'(i));
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'h202);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd23, 32'h203);
      idle(4);

      // x0 is consumed but never written.
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF);
      idle(2);

      // Reset with two buffered entries.
      step(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77);
      step(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
      @(negedge clk);
      chk("pre_rst_pending", 32'(bus.ex_pending), 32'(model_buf.size()));
      bus.ld_valid = 1'b0;
      bus.ex_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      model_buf.delete();
      #1;
      chk_reset_outputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(4);

      // Random mix of loads and pipeline results.
      for (int i = 0; i < 10000; i++) begin
         bit          ldv;
         bit          exv;
         logic [4:0]  ldrd;
         logic [4:0]  exrd;
         logic [31:0] ldd;
         logic [31:0] exd;
         ldv  = ($urandom_range(0, 99) < 35);
         exv  = ($urandom_range(0, 99) < 60);
         ldrd = 5'($urandom_range(0, 31));
         exrd = 5'($urandom_range(0, 31));
         ldd  = $urandom;
         exd  = $urandom;
         step(ldv, ldrd, ldd, exv, exrd, exd);
      end
      idle(6);
      chk("drained_expectations", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two result sources in the RV32I core.
- Source 0 is the integer pipeline result: the already-selected ALU, load or PC+4 value. Source 1 is the multi-cycle load/memory response path.
- Load responses cannot be stalled, so they always win. Pipeline results are held in a small in-order buffer until the port is free.
- Output is a registered write to the register file.

Parameters:
- DataWidth, 32, width of write data.
- RegAddrWidth, 5, register index width.
- Depth, 2, entries in the pipeline-result buffer (power of two, >= 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  pipeline result valid.
- ex_ready  out  1  buffer can accept a pipeline result.
- ex_rd  in  RegAddrWidth  destination register of the pipeline result.
- ex_data  in  DataWidth  pipeline result data.
- ld_valid  in  1  load response valid; always accepted.
- ld_rd  in  RegAddrWidth  load destination register.
- ld_data  in  DataWidth  load data.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  RegAddrWidth  register-file write address.
- rf_wdata  out  DataWidth  register-file write data.
- ex_pending  out  $clog2(Depth)+1  buffered entries not yet written.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Buffer empty, ex_pending=0.
  - No state updates while rst_n is low.
  - Asserting reset mid-operation discards buffered results and any in-flight write.
- ex_ready = !full. It is derived from registered state only, so it is 1 in reset and after.
- Push: ex_valid && ex_ready. A push in a cycle where the buffer is full and also popping is NOT allowed, because ready is already low.
- Per-cycle grant, in priority order:
  1. ld_valid: write the load; the buffer holds; any pushed ex result is enqueued.
  2. Buffer non-empty: pop the head and write it; a concurrent push enqueues at the tail, keeping order.
  3. Buffer empty and ex push: bypass directly to the output register; nothing is enqueued.
  4. Otherwise: rf_we=0 next cycle.
- Latency:
  - Granted source to rf_we/rf_waddr/rf_wdata: exactly 1 cycle, registered.
  - Bypass path: 1 cycle.
  - Buffered entries leave in FIFO order.
- rd==0: the request is accepted, popped or bypassed as normal, but rf_we stays 0 for that cycle. x0 is never written.
- Sustained ld_valid:
  - The buffer fills, then ex_ready drops.
  - Pipeline results are stalled upstream, never dropped.
  - No starvation limit, since the memory side bounds back-to-back responses.
- ex_pending = buffer occupancy, excluding the bypass/output register.
- Ordering hazards between a load and a younger pipeline result to the same rd are guaranteed absent by the hazard unit. This block does not check them.
- Full/empty pointers use one extra wrap bit. Occupancy arithmetic is modulo 2*Depth.

Decomposition:
- wb_pkg:
  - localparams DataWidth and RegAddrWidth.
  - typedef wb_req_t {rd, data}.
  - enum wb_src_e {WB_NONE, WB_LOAD, WB_BUF, WB_BYPASS} for grant select and debug.
- Sub-module wb_fifo:
  - Parameterised sync FIFO of wb_req_t.
  - Ports: push/pop/full/empty/count.
  - Instantiated once.

Test Plan:
- Reset then ex_valid with rd=5, data=0x11 and no load -> next cycle rf_we=1, waddr=5, wdata=0x11; ex_pending stays 0 (bypass).
- Same cycle ld_valid (rd=3, 0xAA) and ex_valid (rd=4, 0xBB) -> cycle+1 writes r3=0xAA; cycle+2 writes r4=0xBB; ex_pending goes 1 then 0.
- ld_valid held 4 cycles with ex_valid every cycle (Depth=2) -> ex_ready low after 2 pushes; then writes r-load x4 followed by ex results in push order; no loss or duplication.
- ex_valid rd=0 data=0xFF -> accepted, rf_we stays 0.
- Buffer holding 2 entries, rst_n pulsed low mid-cycle -> outputs 0 immediately; after release the buffer is empty, ex_pending=0, and no stale writes occur.
- Random mix of ld/ex traffic over 10k cycles -> scoreboard: every accepted ex result is written once, in order, and loads are never delayed.
